// File: rtl/alu_arbiter_pkg.sv
// alu_pkg: shared definitions for the ALU arbiter slice.
//   - Opcode encodings OP_ADD .. OP_PADDSB (all eight codes are legal).
//   - FSM state encoding state_t (IDLE, EXEC, RESP).
//   - flag_we_mask(op): returns {z_we, n_we, v_we} for an opcode.
// Optional feature macro used elsewhere in this slice: ALU_ARBITER_ERR_EN.
package alu_pkg;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_RED    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADDSB = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Arithmetic ops own all three flags, logic/shift ops only report zero,
  // reduction and packed-saturating results leave the flags alone.
  function automatic logic [2:0] flag_we_mask(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB:                 flag_we_mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_we_mask = 3'b100;
      default:                        flag_we_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester and response handshake bundle for alu_arbiter.
//   req0_* / req1_*   : valid/ready request channels carrying op, a, b
//   rsp_*             : registered result channel (valid/ready, data, owner id)
//   rsp_err           : only present when ALU_ARBITER_ERR_EN is defined
// Modports: master = the request/response client side, slave = the arbiter.
interface alu_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
);
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;
`ifdef ALU_ARBITER_ERR_EN
  logic              rsp_err;
`endif

  modport master (
`ifdef ALU_ARBITER_ERR_EN
    input  rsp_err,
`endif
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_data, rsp_id,
    output rsp_ready
  );

  modport slave (
`ifdef ALU_ARBITER_ERR_EN
    output rsp_err,
`endif
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_data, rsp_id,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
//   clk, rst_n     : clock, asynchronous active-low reset
//   valid_i[1:0]   : request valids
//   accept_i       : the current grant is being taken this cycle
//   grant_o[1:0]   : one-hot grant (combinational from valids and last grant)
//   last_grant_o   : index of the most recently accepted requester
// last_grant resets to 1 so that requester 0 wins the first contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o,
  output logic       last_grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  assign last_grant_d = accept_i ? grant_o[1] : last_grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant_o = last_grant_q;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with round-robin
// arbitration, registered operands and result, and the Z/N/V flag register.
//   clk, rst_n              : clock, asynchronous active-low reset
//   bus (slave)             : req0/req1 request channels, rsp result channel
//   alu_in1/in2/opcode      : registered operands/opcode to the ALU
//   alu_cin, alu_inv2       : 1 only for SUB, from the registered opcode
//   alu_out, alu_z/n/v      : ALU result and flags, captured in EXEC
//   flag_z/n/v              : architectural flag register
//   alu_err (input), bus.rsp_err : only with ALU_ARBITER_ERR_EN defined;
//                             an erroring op writes no flags.
// One op takes IDLE/RESP(accept) -> EXEC -> RESP; peak rate 1 op / 2 cycles.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_opcode,
  output logic              alu_cin,
  output logic              alu_inv2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_v,
`ifdef ALU_ARBITER_ERR_EN
  input  logic              alu_err,
`endif
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v
);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_id_q;
  logic              flag_z_q, flag_n_q, flag_v_q;

  logic [1:0]        valid;
  logic [1:0]        grant;
  logic              last_grant;
  logic              can_accept;
  logic              accept;
  logic [2:0]        flag_we;
  logic              flag_block;

  assign valid = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid),
    .accept_i     (accept),
    .grant_o      (grant),
    .last_grant_o (last_grant)
  );

  always_comb begin
    state_d    = state_q;
    can_accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        can_accept = 1'b1;
        if (|valid) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        // Consuming the result frees the operand registers in the same cycle.
        if (bus.rsp_ready) begin
          can_accept = 1'b1;
          state_d    = (|valid) ? ST_EXEC : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept         = can_accept & (|valid);
  assign bus.req0_ready = can_accept & grant[0];
  assign bus.req1_ready = can_accept & grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

`ifdef ALU_ARBITER_ERR_EN
  logic rsp_err_q;
  assign flag_block  = alu_err;
  assign bus.rsp_err = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 rsp_err_q <= 1'b0;
    else if (state_q == ST_EXEC) rsp_err_q <= alu_err;
  end
`else
  assign flag_block = 1'b0;
`endif

  assign flag_we = flag_we_mask(op_q) & {3{~flag_block}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_n_q   <= 1'b0;
      flag_v_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= grant[1] ? bus.req1_op : bus.req0_op;
        a_q  <= grant[1] ? bus.req1_a  : bus.req0_a;
        b_q  <= grant[1] ? bus.req1_b  : bus.req0_b;
      end
      if (state_q == ST_EXEC) begin
        rsp_data_q <= alu_out;
        // No accept can happen during EXEC, so last_grant still names the owner.
        rsp_id_q   <= last_grant;
        if (flag_we[2]) flag_z_q <= alu_z;
        if (flag_we[1]) flag_n_q <= alu_n;
        if (flag_we[0]) flag_v_q <= alu_v;
      end
    end
  end

  assign alu_in1    = a_q;
  assign alu_in2    = b_q;
  assign alu_opcode = op_q;
  assign alu_cin    = (op_q == OP_SUB);
  assign alu_inv2   = (op_q == OP_SUB);

  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
  assign flag_v = flag_v_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter.
// Directed vector table, hand sequences (round robin, backpressure,
// asynchronous reset mid-EXEC) and a randomized phase against a
// queue-based reference model. The bench also plays the ALU.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DW = 16;
  localparam int OW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(DW), .OP_W(OW)) bus();

  logic [DW-1:0] alu_in1, alu_in2, alu_out;
  logic [OW-1:0] alu_opcode;
  logic          alu_cin, alu_inv2, alu_z, alu_n, alu_v;
  logic          flag_z, flag_n, flag_v;
`ifdef ALU_ARBITER_ERR_EN
  logic          alu_err;
  assign alu_err = 1'b0;
`endif

  alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_opcode (alu_opcode),
    .alu_cin    (alu_cin),
    .alu_inv2   (alu_inv2),
    .alu_out    (alu_out),
    .alu_z      (alu_z),
    .alu_n      (alu_n),
    .alu_v      (alu_v),
`ifdef ALU_ARBITER_ERR_EN
    .alu_err    (alu_err),
`endif
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_v     (flag_v)
  );

  // ---------------- reference arithmetic ----------------
  typedef struct packed {
    logic [15:0] r;
    logic z, n, v;
  } res_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] x, input logic [7:0] y);
    int s;
    s = int'($signed(x)) + int'($signed(y));
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return s[7:0];
  endfunction

  function automatic res_t ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    res_t o;
    logic [31:0] t;
    o = '0;
    t = '0;
    case (op)
      OP_ADD:  o.r = a + b;
      OP_SUB:  o.r = a - b;
      OP_XOR:  o.r = a ^ b;
      OP_RED:  o.r = {15'd0, ^{a, b}};
      OP_SLL:  o.r = a << b[3:0];
      OP_SRA:  o.r = 16'($signed(a) >>> b[3:0]);
      OP_ROR:  begin t = {a, a} >> b[3:0]; o.r = t[15:0]; end
      default: o.r = {sat_add8(a[15:8], b[15:8]), sat_add8(a[7:0], b[7:0])};
    endcase
    o.z = (o.r == 16'd0);
    o.n = o.r[15];
    if (op == OP_ADD)      o.v = (a[15] == b[15]) && (o.r[15] != a[15]);
    else if (op == OP_SUB) o.v = (a[15] != b[15]) && (o.r[15] != a[15]);
    else                   o.v = o.r[0] ^ o.r[15];  // junk V the flag rules must ignore
    return o;
  endfunction

  // ALU stand-in: ADD/SUB go through the carry-in/invert inputs like real hardware.
  res_t        stub_res;
  logic [15:0] stub_e;
  always_comb begin
    stub_res = ref_op(alu_opcode, alu_in1, alu_in2);
    stub_e   = alu_inv2 ? ~alu_in2 : alu_in2;
    if (alu_opcode == OP_ADD || alu_opcode == OP_SUB) begin
      stub_res.r = alu_in1 + stub_e + {15'd0, alu_cin};
      stub_res.z = (stub_res.r == 16'd0);
      stub_res.n = stub_res.r[15];
      stub_res.v = (alu_in1[15] == stub_e[15]) && (stub_res.r[15] != alu_in1[15]);
    end
    alu_out = stub_res.r;
    alu_z   = stub_res.z;
    alu_n   = stub_res.n;
    alu_v   = stub_res.v;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic sel, input logic v, input logic [2:0] op,
                           input logic [15:0] a, input logic [15:0] b);
    if (!sel) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  typedef struct {
    logic        sel;
    logic [2:0]  op;
    logic [15:0] a, b, data;
    logic        z, n, v;
  } vec_t;

  vec_t vecs[16];

  // Starts and ends at posedge+2 in IDLE with rsp_ready low.
  task automatic run_vec(input vec_t t);
    drive_req(t.sel, 1'b1, t.op, t.a, t.b);
    #1;
    check("vec_ready_granted", t.sel ? bus.req1_ready : bus.req0_ready, 1);
    check("vec_ready_other",   t.sel ? bus.req0_ready : bus.req1_ready, 0);
    @(posedge clk); #1;
    drive_req(t.sel, 1'b0, t.op, t.a, t.b);
    #1;
    check("exec_in1", alu_in1, t.a);
    check("exec_in2", alu_in2, t.b);
    check("exec_opcode", alu_opcode, t.op);
    check("exec_cin_inv2", {alu_cin, alu_inv2}, (t.op == OP_SUB) ? 2'b11 : 2'b00);
    check("exec_rsp_valid", bus.rsp_valid, 0);
    @(posedge clk); #1;
    check("resp_valid", bus.rsp_valid, 1);
    check("resp_data", bus.rsp_data, t.data);
    check("resp_id", bus.rsp_id, t.sel);
    check("resp_flags_zn_v", {flag_z, flag_n, flag_v}, {t.z, t.n, t.v});
    $display("vec sel=%0d op=%0d a=0x%04h b=0x%04h -> data=0x%04h znv=%b%b%b",
             t.sel, t.op, t.a, t.b, bus.rsp_data, flag_z, flag_n, flag_v);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    #1;
    check("after_rsp_idle", bus.rsp_valid, 0);
  endtask

  // random-phase model state
  typedef struct {
    logic [15:0] data;
    logic        id;
    logic        z, n, v;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic        rv[2];
  logic [2:0]  rop[2];
  logic [15:0] ra[2], rb[2];
  logic        m_last, m_z, m_n, m_v;

  localparam int N_RND = 400;

  initial begin
    logic [1:0] rr_exp[8];
    logic       rr_id_exp[4];
    logic       exp_valid, allowed, win, rsp_rdy, gen;
    logic [1:0] exp_rdy;
    res_t       res;
    exp_t       e;

    bus.req0_valid = 0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 0;

    //              sel   op         a         b         data      z     n     v
    vecs[0]  = '{1'b0, OP_ADD,    16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, OP_XOR,    16'h00F0, 16'h00F0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, OP_SUB,    16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, OP_XOR,    16'h00F0, 16'h000F, 16'h00FF, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, OP_SUB,    16'h0003, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, OP_RED,    16'h0001, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, OP_PADDSB, 16'h7F80, 16'h0180, 16'h7F80, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, OP_SLL,    16'h8001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, OP_ADD,    16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, OP_SRA,    16'h8000, 16'h000F, 16'hFFFF, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, OP_ROR,    16'h0001, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, OP_SUB,    16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, OP_ADD,    16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, OP_PADDSB, 16'h8081, 16'hFFFF, 16'h8080, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, OP_SLL,    16'h0001, 16'h0010, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, OP_ROR,    16'h0003, 16'h0004, 16'h3000, 1'b0, 1'b0, 1'b0};

    // {req1_ready, req0_ready} per cycle with both requesters always valid
    rr_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    rr_id_exp = '{1'b0, 1'b0, 1'b1, 1'b0};

    // ---- reset state ----
    #2;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_alu_in", {alu_in1, alu_in2}, 0);
    check("rst_alu_ctl", {alu_opcode, alu_cin, alu_inv2}, 0);
    check("rst_flags", {flag_z, flag_n, flag_v}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- directed vector table ----
    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // ---- round robin, both valid, rsp_ready held high ----
    bus.rsp_ready = 1'b1;
    drive_req(1'b0, 1'b1, OP_ADD, 16'h0001, 16'h0002);
    drive_req(1'b1, 1'b1, OP_XOR, 16'h0003, 16'h0005);
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rr_ready_c%0d", i), {bus.req1_ready, bus.req0_ready}, rr_exp[i]);
      if (i % 2 == 0 && i > 0) begin
        check($sformatf("rr_rsp_id_c%0d", i), bus.rsp_id, rr_id_exp[i/2]);
        $display("rr cycle=%0d rsp_id=%0d data=0x%04h", i, bus.rsp_id, bus.rsp_data);
      end
      @(posedge clk); #1;
    end
    drive_req(1'b0, 1'b0, OP_ADD, 16'h0, 16'h0);
    drive_req(1'b1, 1'b0, OP_ADD, 16'h0, 16'h0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    #1;
    check("rr_drain_idle", bus.rsp_valid, 0);

    // ---- backpressure in RESP with req1 waiting ----
    drive_req(1'b0, 1'b1, OP_ADD, 16'h1234, 16'h1111);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, OP_ADD, 16'h1234, 16'h1111);
    @(posedge clk); #1;
    drive_req(1'b1, 1'b1, OP_SUB, 16'h0010, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp_req1_ready_c%0d", i), bus.req1_ready, 0);
      check($sformatf("bp_rsp_valid_c%0d", i), bus.rsp_valid, 1);
      check($sformatf("bp_rsp_hold_c%0d", i), {bus.rsp_id, bus.rsp_data}, {1'b0, 16'h2345});
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_req1_ready", bus.req1_ready, 1);
    $display("bp rsp_id=%0d data=0x%04h taken with req1 accept", bus.rsp_id, bus.rsp_data);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    drive_req(1'b1, 1'b0, OP_SUB, 16'h0010, 16'h0001);
    #1;
    check("bp_exec_no_valid", bus.rsp_valid, 0);
    @(posedge clk); #1;
    check("bp_second_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, {1'b1, 1'b1, 16'h000F});
    $display("bp rsp_id=%0d data=0x%04h", bus.rsp_id, bus.rsp_data);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;

    // ---- asynchronous reset while in EXEC ----
    run_vec(vecs[0]);  // leaves N=1, V=1 so the clear is visible
    drive_req(1'b0, 1'b1, OP_SUB, 16'h0005, 16'h0003);
    @(posedge clk); #1;
    check("rst_pre_exec_cin", alu_cin, 1);
    rst_n = 1'b0;
    drive_req(1'b0, 1'b0, OP_SUB, 16'h0005, 16'h0003);
    #1;
    check("arst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, 0);
    check("arst_alu_in", {alu_in1, alu_in2}, 0);
    check("arst_alu_ctl", {alu_opcode, alu_cin, alu_inv2}, 0);
    check("arst_flags", {flag_z, flag_n, flag_v}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("arst_no_rsp_c%0d", i), bus.rsp_valid, 0);
    end
    // last accept before reset was req0; after reset req0 must still win
    drive_req(1'b0, 1'b1, OP_ADD, 16'h0002, 16'h0003);
    drive_req(1'b1, 1'b1, OP_ADD, 16'h0004, 16'h0005);
    #1;
    check("arst_first_contention", {bus.req1_ready, bus.req0_ready}, 2'b01);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, OP_ADD, 16'h0, 16'h0);
    drive_req(1'b1, 1'b0, OP_ADD, 16'h0, 16'h0);
    @(posedge clk); #1;
    check("arst_first_rsp", {bus.rsp_id, bus.rsp_data}, {1'b0, 16'h0005});
    $display("arst rsp_id=%0d data=0x%04h", bus.rsp_id, bus.rsp_data);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;

    // ---- randomized phase against the reference model ----
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_last = 1'b1; m_z = 0; m_n = 0; m_v = 0;
    for (int k = 0; k < 2; k++) begin rv[k] = 0; rop[k] = '0; ra[k] = '0; rb[k] = '0; end

    for (int c = 0; c < N_RND; c++) begin
      gen = (c < N_RND - 12);
      for (int k = 0; k < 2; k++) begin
        if (gen && !rv[k] && $urandom_range(0, 2) != 0) begin
          rv[k]  = 1'b1;
          rop[k] = 3'($urandom_range(0, 7));
          ra[k]  = 16'($urandom);
          rb[k]  = ($urandom_range(0, 3) == 0) ? ra[k] : 16'($urandom);
        end
      end
      rsp_rdy = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive_req(1'b0, rv[0], rop[0], ra[0], rb[0]);
      drive_req(1'b1, rv[1], rop[1], ra[1], rb[1]);
      bus.rsp_ready = rsp_rdy;
      #1;

      exp_valid = (q.size() > 0) && (q[0].due <= c);
      check("rnd_rsp_valid", bus.rsp_valid, exp_valid);
      if (exp_valid) begin
        check("rnd_rsp_data", bus.rsp_data, q[0].data);
        check("rnd_rsp_id", bus.rsp_id, q[0].id);
        check("rnd_flags", {flag_z, flag_n, flag_v}, {q[0].z, q[0].n, q[0].v});
      end

      allowed = (q.size() == 0) || (exp_valid && rsp_rdy);
      win     = (rv[0] && rv[1]) ? ~m_last : rv[1];
      exp_rdy = (allowed && (rv[0] || rv[1])) ? (win ? 2'b10 : 2'b01) : 2'b00;
      check("rnd_ready", {bus.req1_ready, bus.req0_ready}, exp_rdy);

      if (exp_valid && rsp_rdy) begin
        $display("rnd cycle=%0d rsp_id=%0d data=0x%04h znv=%b%b%b",
                 c, bus.rsp_id, bus.rsp_data, flag_z, flag_n, flag_v);
        void'(q.pop_front());
      end
      if (exp_rdy != 2'b00) begin
        res = ref_op(rop[win], ra[win], rb[win]);
        case (rop[win])
          OP_ADD, OP_SUB: begin m_z = res.z; m_n = res.n; m_v = res.v; end
          OP_XOR, OP_SLL, OP_SRA, OP_ROR: m_z = res.z;
          default: ;
        endcase
        e.data = res.r; e.id = win; e.z = m_z; e.n = m_n; e.v = m_v; e.due = c + 2;
        q.push_back(e);
        m_last  = win;
        rv[win] = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("rnd_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
